// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add MUL, restoring DIV, one shared adder.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero multiplies finish at capture.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       f3_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [1:0]       state_o
);
    // Handshake: start_i is accepted only in IDLE (stall_o high that cycle); done_o pulses
    // for one cycle with result_o valid, and result_o then holds until the next accepted op.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [WIDTH-1:0]    opb_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [CW-1:0]       cnt_q;

    logic                sa, sb, a_neg, b_neg, b_zero, cap_neg;
    logic [WIDTH-1:0]    a_abs, b_abs;
    logic                is_div;
    logic [WIDTH:0]      shifted, add_x, add_y, sum;
    logic [2*WIDTH-1:0]  fix_src, fix_val;
    logic [WIDTH-1:0]    fix_res;

    // Operand conditioning at capture: magnitudes plus the sign to restore in FIX.
    always_comb begin
        sa      = f3_i[2] ? ~f3_i[0] : (f3_i != 3'b011);
        sb      = f3_i[2] ? ~f3_i[0] : ~f3_i[1];
        a_neg   = sa & rs1_i[WIDTH-1];
        b_neg   = sb & rs2_i[WIDTH-1];
        a_abs   = a_neg ? -rs1_i : rs1_i;
        b_abs   = b_neg ? -rs2_i : rs2_i;
        b_zero  = (rs2_i == '0);
        // A zero divisor must yield an all-ones quotient, so its sign is never applied.
        cap_neg = f3_i[2] ? (f3_i[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero)) : (a_neg ^ b_neg);
    end

    // Shared WIDTH+1 adder: add multiplicand for MUL, subtract divisor for DIV.
    always_comb begin
        is_div  = op_q[2];
        shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        add_x   = is_div ? shifted : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        add_y   = is_div ? ~{1'b0, opb_q} : (acc_q[0] ? {1'b0, opb_q} : '0);
        sum     = add_x + add_y + (WIDTH+1)'(is_div);
    end

    always_comb begin
        fix_src = is_div ? {{WIDTH{1'b0}}, (op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0])}
                         : acc_q;
        fix_val = neg_q ? -fix_src : fix_src;
        fix_res = (is_div || op_q[1:0] == 2'b00) ? fix_val[WIDTH-1:0]
                                                 : fix_val[2*WIDTH-1:WIDTH];
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic             early_hit;
    logic [WIDTH-1:0] early_res;

    always_comb begin
        early_hit = 1'b0;
        early_res = '0;
        if (f3_i[2]) begin
            if (b_zero) begin
                early_hit = 1'b1;
                early_res = f3_i[1] ? rs1_i : '1;
            end else if (!f3_i[0] && rs1_i == {1'b1, {(WIDTH-1){1'b0}}} && (&rs2_i)) begin
                early_hit = 1'b1;
                early_res = f3_i[1] ? '0 : rs1_i;
            end
        end else if (rs1_i == '0 || b_zero) begin
            early_hit = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        op_q  <= f3_i;
                        neg_q <= cap_neg;
                        cnt_q <= '0;
                        opb_q <= f3_i[2] ? b_abs : a_abs;
                        acc_q <= {{WIDTH{1'b0}}, (f3_i[2] ? a_abs : b_abs)};
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit) begin
                            state_q  <= DONE;
                            done_o   <= 1'b1;
                            result_o <= early_res;
                        end else begin
                            state_q <= CALC;
                        end
`else
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        // DIV: sum[WIDTH] set means the trial subtraction went negative; restore.
                        if (is_div)
                            acc_q <= sum[WIDTH] ? {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                                : {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        else
                            acc_q <= {sum, acc_q[WIDTH-1:1]};
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH-1))
                            state_q <= FIX;
                    end
                end
                FIX: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        result_o <= fix_res;
                        done_o   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q == CALC) || (state_q == FIX);
    assign stall_o = (start_i && state_q == IDLE) || busy_o;
    assign state_o = state_q;

endmodule
